// File: rtl/ip_sched_pkg.sv
// Shared types and constants for the ip_backward layer-pass scheduler.
package ip_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef logic [31:0] ip_word_t;

  localparam int MULT_DELAY = 5;
  localparam int ADD_DELAY  = 7;

  // Multiplier stage, one adder per tree level plus the bias add, and an output register.
  function automatic int default_pipe_lat(input int width, input int mult_delay,
                                          input int add_delay);
    return mult_delay + add_delay * ($clog2(width) + 1) + 1;
  endfunction

endpackage

// File: rtl/ip_result_fifo.sv
// Result FIFO: holds {row index, datapath result} until the consumer takes it.
module ip_result_fifo #(
  parameter int  DEPTH = 8,
  parameter int  DW    = 40,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          not_empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !do_push));
  end

endmodule

// File: rtl/ip_backward_sched.sv
// Sequences one fully-connected layer pass through the fixed-latency ip_backward datapath,
// with credit-based issue so every in-flight result has a guaranteed FIFO slot.
module ip_backward_sched
  import ip_sched_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter int  PIPE_LAT   = default_pipe_lat(WIDTH, MULT_DELAY, ADD_DELAY),
  parameter int  FIFO_DEPTH = 8,
  parameter int  MAX_OUT    = 256,
  localparam int AW         = $clog2(MAX_OUT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AW:0]               num_out,
  input  ip_word_t [WIDTH-1:0]      in_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      w_rd_en,
  output logic [AW-1:0]             w_rd_addr,
  input  ip_word_t [WIDTH-1:0]      w_rd_data,
  output logic                      b_rd_en,
  output logic [AW-1:0]             b_rd_addr,
  input  ip_word_t                  b_rd_data,
  output logic                      dp_valid,
  output ip_word_t [WIDTH-1:0]      dp_in_data,
  output ip_word_t [WIDTH-1:0]      dp_weights,
  output ip_word_t                  dp_bias,
  output logic [7:0]                dp_in_id,
  input  ip_word_t                  dp_out_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output ip_word_t                  res_data,
  output logic [AW-1:0]             res_idx
);

  localparam int STAGES = PIPE_LAT + 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  state_t               state, state_nxt;
  logic [AW:0]          n_out, rd_cnt;
  ip_word_t [WIDTH-1:0] in_lat;
  logic [CW-1:0]        inflight, fifo_count;
  logic                 accept, rd, wr, pop, credit_ok, drain_empty;

  // Stage k of the delay line holds the read issued k cycles ago.
  logic [STAGES:1]           vld_q;
  logic [STAGES:1][AW-1:0]   idx_q;
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][AW-1:0]   idx_pipe;

  assign vld_pipe = {vld_q, rd};
  assign idx_pipe = {idx_q, rd_cnt[AW-1:0]};
  assign wr       = vld_pipe[STAGES];
  assign pop      = res_valid && res_ready;

  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  // Leave DRAIN in the cycle the last entry is popped so done lands one cycle later.
  assign drain_empty = (inflight == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd        = 1'b0;
    case (state)
      IDLE: begin
        if (start && (num_out != '0)) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        rd = credit_ok;
        if (credit_ok && (rd_cnt == n_out - 1'b1)) state_nxt = DRAIN;
      end
      DRAIN:   if (drain_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n_out    <= '0;
      rd_cnt   <= '0;
      in_lat   <= '0;
      inflight <= '0;
      vld_q    <= '0;
      idx_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        n_out  <= num_out;
        in_lat <= in_vec;
        rd_cnt <= '0;
      end else if (rd) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      inflight <= inflight + CW'(rd) - CW'(wr);
      vld_q    <= vld_pipe[STAGES-1:0];
      idx_q    <= idx_pipe[STAGES-1:0];
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign w_rd_en    = rd;
  assign w_rd_addr  = rd_cnt[AW-1:0];
  assign b_rd_en    = rd;
  assign b_rd_addr  = rd_cnt[AW-1:0];
  assign dp_valid   = vld_q[1];
  assign dp_in_id   = 8'(idx_q[1]);
  assign dp_in_data = in_lat;
  assign dp_weights = w_rd_data;
  assign dp_bias    = b_rd_data;

  ip_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (AW + 32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr),
    .push_data ({idx_q[STAGES], dp_out_data}),
    .pop       (pop),
    .head      ({res_idx, res_data}),
    .not_empty (res_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ip_backward_sched.sv
// Directed/randomized bench for ip_backward_sched with RAM and datapath models and a row scoreboard.
`timescale 1ns/1ps
module tb_ip_backward_sched;
  import ip_sched_pkg::*;

  localparam int WIDTH = 8, PIPE_LAT = 34, FIFO_DEPTH = 8, MAX_OUT = 256, AW = 8;

  logic clk = 1'b0;
  logic reset, start, res_ready;
  logic [AW:0] num_out;
  logic [WIDTH-1:0][31:0] in_vec, w_rd_data, dp_in_data, dp_weights;
  logic [31:0] b_rd_data, dp_bias, dp_out_data, res_data;
  logic busy, done, w_rd_en, b_rd_en, dp_valid, res_valid;
  logic [AW-1:0] w_rd_addr, b_rd_addr, res_idx;
  logic [7:0] dp_in_id;

  always #5 clk = ~clk;

  ip_backward_sched #(.WIDTH(WIDTH), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH),
                      .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_out(num_out), .in_vec(in_vec),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .b_rd_data(b_rd_data), .dp_valid(dp_valid), .dp_in_data(dp_in_data),
    .dp_weights(dp_weights), .dp_bias(dp_bias), .dp_in_id(dp_in_id),
    .dp_out_data(dp_out_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
  );

  // Parameter RAMs: one-cycle read latency.
  logic [WIDTH-1:0][31:0] wmem [MAX_OUT];
  logic [31:0]            bmem [MAX_OUT];
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
  end

  function automatic logic [31:0] dot(input logic [WIDTH-1:0][31:0] a,
                                      input logic [WIDTH-1:0][31:0] w, input logic [31:0] b);
    logic [31:0] s;
    s = b;
    for (int i = 0; i < WIDTH; i++) s += a[i] * w[i];
    return s;
  endfunction

  // Behavioural datapath: result of the inputs seen with dp_valid appears PIPE_LAT cycles later.
  logic [31:0] dp_line [PIPE_LAT];
  always @(posedge clk) begin
    dp_line[0] <= dot(dp_in_data, dp_weights, dp_bias);
    for (int k = 1; k < PIPE_LAT; k++) dp_line[k] <= dp_line[k-1];
  end
  assign dp_out_data = dp_line[PIPE_LAT-1];

  int checks = 0, failures = 0;
  int cyc = 0, n_reads, n_pops, n_done, exp_idx;
  int first_rd, last_rd, first_val, first_pop, last_pop, done_cyc, max_outst;
  logic [WIDTH-1:0][31:0] job_vec;
  logic       prev_rd = 1'b0;
  logic [7:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply res_ready, then sample mid-cycle and score everything visible.
  task automatic cycle(input bit rdy);
    @(negedge clk);
    res_ready = rdy;
    #1;
    cyc++;
    if (dp_valid || prev_rd) begin
      chk("dp_valid", dp_valid, prev_rd);
      chk("dp_in_id", dp_in_id, prev_addr);
      chk("dp_in_data", dp_in_data, job_vec);
      chk("dp_weights", dp_weights, wmem[prev_addr]);
      chk("dp_bias", dp_bias, bmem[prev_addr]);
    end
    if (w_rd_en || b_rd_en) chk("b_rd_follows_w", {b_rd_en, b_rd_addr}, {w_rd_en, w_rd_addr});
    if (w_rd_en) begin
      chk("w_rd_addr", w_rd_addr, n_reads[AW-1:0]);
      n_reads++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (n_reads - n_pops > max_outst) max_outst = n_reads - n_pops;
    if (res_valid && first_val < 0) first_val = cyc;
    if (res_valid && res_ready) begin
      chk("res_idx", res_idx, exp_idx[AW-1:0]);
      chk("res_data", res_data, dot(job_vec, wmem[exp_idx % MAX_OUT], bmem[exp_idx % MAX_OUT]));
      exp_idx++;
      n_pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_rd   = w_rd_en;
    prev_addr = w_rd_addr;
  endtask

  task automatic start_job(input int n, input bit rdy);
    n_reads = 0; n_pops = 0; n_done = 0; exp_idx = 0; max_outst = 0;
    first_rd = -1; last_rd = -1; first_val = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
    for (int i = 0; i < WIDTH; i++) in_vec[i] = $urandom;
    job_vec = in_vec;
    num_out = (AW + 1)'(n);
    start = 1'b1;
    cycle(rdy);
    start = 1'b0;
    // Scramble the live input so only the latched copy can produce correct sums.
    for (int i = 0; i < WIDTH; i++) in_vec[i] = $urandom;
  endtask

  task automatic run(input int budget, input bit random_ready);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      cycle(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    chk("job_done_within_budget", n_done != 0, 1'b1);
    cycle(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; res_ready = 1'b0; num_out = '0; in_vec = '0; job_vec = '0;
    n_reads = 0; n_pops = 0; n_done = 0; exp_idx = 0; max_outst = 0;
    for (int r = 0; r < MAX_OUT; r++) begin
      for (int i = 0; i < WIDTH; i++) wmem[r][i] = $urandom;
      bmem[r] = $urandom;
    end
    repeat (3) cycle(1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_w_rd_en", {w_rd_en, b_rd_en, w_rd_addr}, '0);
    chk("reset_dp", {dp_valid, dp_in_id, dp_in_data}, '0);
    chk("reset_res", {res_valid, res_idx, res_data}, '0);
    reset = 1'b0;
    cycle(1'b1);

    // Short job, consumer always ready: back-to-back reads and single-entry push/pop.
    start_job(4, 1'b1);
    run(200, 1'b0);
    chk("t1_reads", n_reads, 4);
    chk("t1_reads_consecutive", last_rd - first_rd, 3);
    chk("t1_first_res_latency", first_val - first_rd, PIPE_LAT + 2);
    chk("t1_pops", n_pops, 4);
    chk("t1_no_bubble", last_pop - first_pop, 3);
    chk("t1_done_after_pop", done_cyc - last_pop, 1);
    chk("t1_done_count", n_done, 1);
    chk("t1_idle", busy, 1'b0);

    // Blocked consumer: credits stop issue at FIFO_DEPTH.
    start_job(20, 1'b0);
    repeat (60) cycle(1'b0);
    chk("t2_reads_blocked", n_reads, FIFO_DEPTH);
    chk("t2_res_valid", res_valid, 1'b1);
    chk("t2_busy", busy, 1'b1);
    run(400, 1'b0);
    chk("t2_reads", n_reads, 20);
    chk("t2_pops", n_pops, 20);
    chk("t2_done_count", n_done, 1);

    // Full-size job with a random consumer.
    start_job(256, 1'b1);
    run(8000, 1'b1);
    chk("t3_reads", n_reads, 256);
    chk("t3_pops", n_pops, 256);
    chk("t3_max_outstanding_ok", max_outst <= FIFO_DEPTH, 1'b1);
    chk("t3_done_count", n_done, 1);

    // Zero-length start is ignored.
    start_job(0, 1'b1);
    chk("t4_zero_busy", busy, 1'b0);
    repeat (10) cycle(1'b1);
    chk("t4_zero_no_done", n_done, 0);
    chk("t4_zero_no_reads", n_reads, 0);

    // Start while busy is ignored; results still use the first job's vector.
    start_job(3, 1'b1);
    cycle(1'b1);
    num_out = 9'd5;
    start = 1'b1;
    cycle(1'b1);
    start = 1'b0;
    run(200, 1'b0);
    chk("t4_busy_reads", n_reads, 3);
    chk("t4_busy_pops", n_pops, 3);
    repeat (5) cycle(1'b1);
    chk("t4_no_second_job", busy, 1'b0);

    // Reset while results are still in flight.
    start_job(3, 1'b1);
    for (int k = 0; k < 20 && n_reads < 3; k++) cycle(1'b1);
    repeat (3) cycle(1'b1);
    chk("t5_in_drain", {busy, res_valid}, 2'b10);
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    chk("t5_reset_busy", busy, 1'b0);
    chk("t5_reset_res_valid", res_valid, 1'b0);
    chk("t5_reset_done", done, 1'b0);
    n_pops = 0; n_done = 0;
    repeat (50) cycle(1'b1);
    chk("t5_no_stale_pops", n_pops, 0);
    chk("t5_no_done", n_done, 0);
    start_job(2, 1'b1);
    run(200, 1'b0);
    chk("t5_after_reset_pops", n_pops, 2);
    chk("t5_after_reset_done", n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ip_backward_sched.md
Name: ip_backward_sched

Overview:
- Sequences one fully-connected layer pass through the pipelined `ip_backward` datapath (WIDTH lanes, fixed latency).
- Per job: latches the shared input vector, then streams NUM_OUT weight rows and biases from the parameter RAMs. Issues at most one dot product per cycle, tagged with an 8-bit ID.
- Captures each result after the fixed pipeline latency into an output FIFO, drained by a valid/ready consumer.
- Sits between the layer sequencer (start/done) and the `ip_backward` instance.

Parameters:
- WIDTH, 8, vector lanes (power of 2, ≥2)
- PIPE_LAT, 34, cycles from `dp_valid` to valid `dp_out_data` (mult 5 + add 7×(log2 WIDTH+1) + 1)
- FIFO_DEPTH, 8, result FIFO entries (power of 2)
- MAX_OUT, 256, maximum outputs per job; addresses are $clog2(MAX_OUT) bits (AW)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  job request; accepted only in IDLE
- num_out  in  AW+1  outputs in job, sampled on accepted start; 1..MAX_OUT
- in_vec  in  32×WIDTH  input vector, sampled on accepted start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last result is popped
- w_rd_en  out  1  weight-row read
- w_rd_addr  out  AW  row index
- w_rd_data  in  32×WIDTH  row data, valid 1 cycle after w_rd_en
- b_rd_en  out  1  bias read, always equal to w_rd_en
- b_rd_addr  out  AW  bias index, always equal to w_rd_addr
- b_rd_data  in  32  bias, valid 1 cycle after b_rd_en
- dp_valid  out  1  issue strobe to datapath
- dp_in_data  out  32×WIDTH  latched in_vec
- dp_weights  out  32×WIDTH  w_rd_data pass-through
- dp_bias  out  32  b_rd_data pass-through
- dp_in_id  out  8  low 8 bits of row index
- dp_out_data  in  32  datapath result
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer accepts
- res_data  out  32  FIFO head result
- res_idx  out  AW  FIFO head row index

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; FIFO empty. Reset mid-job aborts it immediately: in-flight delay line and FIFO are flushed, and no done pulse is generated.
- States and transitions:
  - IDLE: on start, latch in_vec and num_out, clear counters, go to ISSUE. start with num_out==0 is ignored (stay IDLE, no done).
  - ISSUE: read row `rd_cnt` when `credit_ok`.
    - `credit_ok` = (inflight + fifo_count) < FIFO_DEPTH. `inflight` counts reads issued but not yet written into the FIFO.
    - On a read, `rd_cnt` increments. After row num_out-1 is read, go to DRAIN.
  - DRAIN: wait until inflight==0 and the FIFO is empty, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Issue pipeline:
  - Read at cycle t → dp_valid=1 at t+1, carrying the row data and dp_in_id=row[7:0].
  - A PIPE_LAT+1-deep valid/index delay line accompanies the read. The FIFO writes dp_out_data and the index at cycle t+1+PIPE_LAT.
  - dp_in_data is held stable for the whole job.
- Credit accounting:
  - In the same cycle, inflight += read, inflight -= FIFO write; both may occur simultaneously.
  - The FIFO can never overflow. An overflow attempt is an assertion failure.
- FIFO: simultaneous push and pop allowed when non-empty, with count unchanged. A pop occurs when res_valid && res_ready. res_data/res_idx come straight from the head entry.
- Throughput: with res_ready held high and PIPE_LAT+1 < FIFO_DEPTH, one read per cycle. Otherwise reads are credit-limited to FIFO_DEPTH per PIPE_LAT+1 window.
- start while busy is ignored.

Decomposition:
- Package `ip_sched_pkg`:
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - `ip_word_t` (32-bit)
  - localparam function for the default PIPE_LAT from WIDTH/MULT_DELAY/ADD_DELAY
- Sub-module `ip_result_fifo`: synchronous FIFO of {idx, data}, with count output.

Test Plan:
- Reset then start, num_out=4, res_ready=1, behavioural `ip_backward` model (PIPE_LAT=34) → reads on 4 consecutive cycles. First res_valid 36 cycles after first w_rd_en; res_idx 0,1,2,3 with correct sums; done 1 cycle after last pop.
- num_out=20, res_ready=0 → exactly 8 reads issued, then w_rd_en stays 0. Raising res_ready → remaining 12 issue; all 20 results arrive in order with no loss.
- Random res_ready (50%), num_out=256, randomized data vs. reference model → 256 correct results, idx 0..255 monotonic; FIFO count never exceeds 8.
- start pulsed with num_out=0 → busy stays 0 and no done. start asserted while busy → ignored; in_vec latch unchanged.
- reset asserted in DRAIN with 3 entries in flight → next cycle: busy=0, res_valid=0, no done. A subsequent job with num_out=2 completes correctly, with no stale results.
- Single-entry simultaneous push/pop at steady state → FIFO count stays 1 and no bubble appears.
